bus_arbiter: RTL and testbench

BUS_ARBITER -- requirements
Module: bus_arbiter

---
 rtl/bus_arbiter_pkg.sv | 18 +
 rtl/bus_arbiter_pick.sv | 23 ++
 rtl/bus_arbiter.sv | 164 ++++++++++++++++
 tb/tb_bus_arbiter.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/bus_arbiter_pkg.sv
// rtl/bus_arbiter_pkg.sv - shared types and constants for the two-port bus arbiter
package bus_arbiter_pkg;

   // Transaction phases: wait for a request, drive the RAM, report completion
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_RESP   = 2'd2
   } state_t;

   // Requester indices: fetch unit and load/store unit
   localparam logic PORT_FETCH = 1'b0;
   localparam logic PORT_LSU   = 1'b1;

   // Width of the RAM wait-cycle counter
   localparam int WAIT_W = 4;

endpackage

// File: rtl/bus_arbiter_pick.sv
// rtl/bus_arbiter_pick.sv - combinational grant selection between the two requesters
module bus_arbiter_pick
   import bus_arbiter_pkg::*;
(
   input  logic [1:0] req,
   input  logic       last,
   output logic       grant,
   output logic       grant_valid
);

   // A lone request wins outright; a tie goes to the port that was not granted last
   always_comb begin
      grant       = PORT_FETCH;
      grant_valid = |req;
      case (req)
         2'b01:   grant = PORT_FETCH;
         2'b10:   grant = PORT_LSU;
         2'b11:   grant = ~last;
         default: grant = PORT_FETCH;
      endcase
   end

endmodule

// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - two-port RAM bus arbiter; BUS_ARBITER_RR_EN selects round-robin tie-break
module bus_arbiter
   import bus_arbiter_pkg::*;
#(
   parameter int WAIT_CYCLES = 1,
   parameter int ADDR_W      = 64,
   parameter int DATA_W      = 64
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              p0_req,
   input  logic              p0_we,
   input  logic [ADDR_W-1:0] p0_addr,
   input  logic [DATA_W-1:0] p0_wdata,
   output logic [DATA_W-1:0] p0_rdata,
   output logic              p0_done,
   input  logic              p1_req,
   input  logic              p1_we,
   input  logic [ADDR_W-1:0] p1_addr,
   input  logic [DATA_W-1:0] p1_wdata,
   output logic [DATA_W-1:0] p1_rdata,
   output logic              p1_done,
   output logic              ram_cs,
   output logic              ram_we,
   output logic              ram_oe,
   output logic [ADDR_W-1:0] bus_addr,
   output logic [DATA_W-1:0] bus_wdata,
   output logic              bus_wdata_oe,
   input  logic [DATA_W-1:0] bus_rdata
);

   localparam logic [WAIT_W-1:0] LAST_CNT = WAIT_W'(WAIT_CYCLES - 1);

   state_t              state;
   state_t              state_nxt;
   logic [WAIT_W-1:0]   cnt;
   logic                grant_q;
   logic                we_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [DATA_W-1:0]   wdata_q;
   logic [DATA_W-1:0]   rdata0_q;
   logic [DATA_W-1:0]   rdata1_q;
   logic                pick_grant;
   logic                pick_valid;
   logic                last_sel;
   logic                take;
   logic                last_access;

   // A new transaction starts whenever IDLE sees any request
   assign take        = (state == ST_IDLE) && pick_valid;
   assign last_access = (state == ST_ACCESS) && (cnt == LAST_CNT);

`ifdef BUS_ARBITER_RR_EN
   logic last_q;

   // Remember which port won the most recent grant so ties alternate
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         last_q <= PORT_LSU;
      else if (take)
         last_q <= pick_grant;
   end

   assign last_sel = last_q;
`else
   // Pretending fetch was granted last makes every tie go to the load/store port
   assign last_sel = PORT_FETCH;
`endif

   bus_arbiter_pick u_pick (
      .req         ({p1_req, p0_req}),
      .last        (last_sel),
      .grant       (pick_grant),
      .grant_valid (pick_valid)
   );

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         state <= ST_IDLE;
      else
         state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:   if (pick_valid)  state_nxt = ST_ACCESS;
         ST_ACCESS: if (last_access) state_nxt = ST_RESP;
         ST_RESP:                    state_nxt = ST_IDLE;
         default:                    state_nxt = ST_IDLE;
      endcase
   end

   // Capture the winner's operands on grant so requester changes are ignored mid-transaction
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         grant_q <= PORT_FETCH;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
      end else if (take) begin
         grant_q <= pick_grant;
         we_q    <= pick_grant ? p1_we    : p0_we;
         addr_q  <= pick_grant ? p1_addr  : p0_addr;
         wdata_q <= pick_grant ? p1_wdata : p0_wdata;
      end
   end

   // Wait counter: cleared on grant, counts every ACCESS cycle
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         cnt <= '0;
      else if (take)
         cnt <= '0;
      else if (state == ST_ACCESS)
         cnt <= cnt + 1'b1;
   end

   // Register read data on the final ACCESS cycle into the granted port's holding register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rdata0_q <= '0;
         rdata1_q <= '0;
      end else if (last_access && !we_q) begin
         if (grant_q == PORT_LSU)
            rdata1_q <= bus_rdata;
         else
            rdata0_q <= bus_rdata;
      end
   end

   assign p0_rdata = rdata0_q;
   assign p1_rdata = rdata1_q;

   // Outputs: RAM strobes only in ACCESS, one done pulse for the granted port in RESP
   always_comb begin
      ram_cs       = 1'b0;
      ram_we       = 1'b0;
      ram_oe       = 1'b0;
      bus_addr     = '0;
      bus_wdata    = '0;
      bus_wdata_oe = 1'b0;
      p0_done      = 1'b0;
      p1_done      = 1'b0;
      case (state)
         ST_ACCESS: begin
            ram_cs       = 1'b1;
            ram_we       = we_q;
            ram_oe       = ~we_q;
            bus_addr     = addr_q;
            bus_wdata    = wdata_q;
            bus_wdata_oe = we_q;
         end
         ST_RESP: begin
            p0_done = (grant_q == PORT_FETCH);
            p1_done = (grant_q == PORT_LSU);
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_bus_arbiter.sv
// tb/tb_bus_arbiter.sv - scoreboard bench for bus_arbiter at WAIT_CYCLES=1 and 3
module tb_bus_arbiter;

   typedef struct {
      logic        port;
      logic        we;
      logic [63:0] addr;
      logic [63:0] wdata;
      logic [63:0] rdata;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;

   logic        clk = 1'b0;
   logic        reset;
   logic        p0_req, p0_we, p1_req, p1_we;
   logic [63:0] p0_addr, p0_wdata, p1_addr, p1_wdata, bus_rdata;
   logic        sel3;

   logic [63:0] a_p0_rdata, a_p1_rdata, a_bus_addr, a_bus_wdata;
   logic        a_p0_done, a_p1_done, a_ram_cs, a_ram_we, a_ram_oe, a_wdata_oe;
   logic [63:0] b_p0_rdata, b_p1_rdata, b_bus_addr, b_bus_wdata;
   logic        b_p0_done, b_p1_done, b_ram_cs, b_ram_we, b_ram_oe, b_wdata_oe;

   logic [63:0] o_rd0, o_rd1, o_addr, o_wdata;
   logic        o_d0, o_d1, o_cs, o_we, o_oe, o_wdoe;

   always #5 clk = ~clk;

   bus_arbiter #(.WAIT_CYCLES(1), .ADDR_W(64), .DATA_W(64)) u_w1 (
      .clk(clk), .reset(reset),
      .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
      .p0_rdata(a_p0_rdata), .p0_done(a_p0_done),
      .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
      .p1_rdata(a_p1_rdata), .p1_done(a_p1_done),
      .ram_cs(a_ram_cs), .ram_we(a_ram_we), .ram_oe(a_ram_oe),
      .bus_addr(a_bus_addr), .bus_wdata(a_bus_wdata), .bus_wdata_oe(a_wdata_oe),
      .bus_rdata(bus_rdata)
   );

   bus_arbiter #(.WAIT_CYCLES(3), .ADDR_W(64), .DATA_W(64)) u_w3 (
      .clk(clk), .reset(reset),
      .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
      .p0_rdata(b_p0_rdata), .p0_done(b_p0_done),
      .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
      .p1_rdata(b_p1_rdata), .p1_done(b_p1_done),
      .ram_cs(b_ram_cs), .ram_we(b_ram_we), .ram_oe(b_ram_oe),
      .bus_addr(b_bus_addr), .bus_wdata(b_bus_wdata), .bus_wdata_oe(b_wdata_oe),
      .bus_rdata(bus_rdata)
   );

   assign o_rd0   = sel3 ? b_p0_rdata  : a_p0_rdata;
   assign o_rd1   = sel3 ? b_p1_rdata  : a_p1_rdata;
   assign o_addr  = sel3 ? b_bus_addr  : a_bus_addr;
   assign o_wdata = sel3 ? b_bus_wdata : a_bus_wdata;
   assign o_d0    = sel3 ? b_p0_done   : a_p0_done;
   assign o_d1    = sel3 ? b_p1_done   : a_p1_done;
   assign o_cs    = sel3 ? b_ram_cs    : a_ram_cs;
   assign o_we    = sel3 ? b_ram_we    : a_ram_we;
   assign o_oe    = sel3 ? b_ram_oe    : a_ram_oe;
   assign o_wdoe  = sel3 ? b_wdata_oe  : a_wdata_oe;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Watch the selected instance until n completions; compare each against the queue head
   task automatic monitor(input int n, input int w);
      int   cyc = 0;
      int   last_done = 0;
      int   got = 0;
      int   cs_cnt = 0;
      exp_t e;
      while (got < n && cyc < 60) begin
         bus_rdata = (sb.size() > 0) ? sb[0].rdata : 64'h0;
         @(posedge clk);
         #1;
         cyc++;
         if (sb.size() == 0) break;
         e = sb[0];
         if (o_cs) begin
            cs_cnt++;
            chk("bus_addr", o_addr, e.addr);
            chk("ram_we", {63'h0, o_we}, {63'h0, e.we});
            chk("ram_oe", {63'h0, o_oe}, {63'h0, ~e.we});
            chk("bus_wdata_oe", {63'h0, o_wdoe}, {63'h0, e.we});
            if (e.we) chk("bus_wdata", o_wdata, e.wdata);
         end
         if (o_d0 || o_d1) begin
            void'(sb.pop_front());
            got++;
            chk("p0_done", {63'h0, o_d0}, {63'h0, ~e.port});
            chk("p1_done", {63'h0, o_d1}, {63'h0, e.port});
            chk("cs_in_resp", {63'h0, o_cs}, 64'h0);
            chk("cs_cycles", 64'(cs_cnt), 64'(w));
            chk("latency", 64'(cyc - last_done), 64'((got == 1) ? w + 1 : w + 2));
            cs_cnt    = 0;
            last_done = cyc;
            if (!e.we) chk("rdata", e.port ? o_rd1 : o_rd0, e.rdata);
         end
      end
      total++;
      assert (got == n) else begin
         bad++;
         $error("FAIL timeout completions=%0d expected=%0d", got, n);
      end
   endtask

   initial begin
      int dones;
      reset = 1'b0; sel3 = 1'b0;
      p0_req = 0; p0_we = 0; p0_addr = '0; p0_wdata = '0;
      p1_req = 0; p1_we = 0; p1_addr = '0; p1_wdata = '0;
      bus_rdata = '0;

      // Reset state
      idle(2);
      chk("rst_ram_cs", {63'h0, a_ram_cs}, 64'h0);
      chk("rst_p0_done", {63'h0, a_p0_done}, 64'h0);
      chk("rst_p1_rdata", a_p1_rdata, 64'h0);
      chk("rst_bus_addr", b_bus_addr, 64'h0);
      reset = 1'b1;
      idle(1);
      chk("idle_ram_cs", {63'h0, a_ram_cs}, 64'h0);

      // WAIT_CYCLES=1 fetch read
      p0_req = 1; p0_we = 0; p0_addr = 64'h100;
      sb.push_back('{1'b0, 1'b0, 64'h100, 64'h0, 64'hDEADBEEF00000013});
      monitor(1, 1);
      p0_req = 0;
      idle(1);
      chk("p0_rdata_hold", a_p0_rdata, 64'hDEADBEEF00000013);
      idle(5);

      // WAIT_CYCLES=1 load/store write
      p1_req = 1; p1_we = 1; p1_addr = 64'h200; p1_wdata = 64'h55;
      sb.push_back('{1'b1, 1'b1, 64'h200, 64'h55, 64'h0});
      monitor(1, 1);
      p1_req = 0; p1_we = 0;
      idle(5);

      // Both requesting for four back-to-back transactions
      p0_addr = 64'h300; p1_addr = 64'h400; p0_we = 0; p1_we = 0;
      for (int i = 0; i < 4; i++) begin
         logic pt;
`ifdef BUS_ARBITER_RR_EN
         pt = (i % 2 == 1);
`else
         pt = 1'b1;
`endif
         sb.push_back('{pt, 1'b0, pt ? 64'h400 : 64'h300, 64'h0, 64'h1111 * 64'(i + 1)});
      end
      p0_req = 1; p1_req = 1;
      monitor(4, 1);
      p0_req = 0; p1_req = 0;
      idle(6);

      // WAIT_CYCLES=3 fetch read
      sel3 = 1'b1;
      p0_req = 1; p0_we = 0; p0_addr = 64'h180;
      sb.push_back('{1'b0, 1'b0, 64'h180, 64'h0, 64'h0123456789ABCDEF});
      monitor(1, 3);
      p0_req = 0;
      idle(6);

      // Reset in the second ACCESS cycle aborts without a done pulse
      p0_req = 1; p0_we = 0; p0_addr = 64'h500;
      idle(2);
      chk("abort_pre_cs", {63'h0, b_ram_cs}, 64'h1);
      #2 reset = 1'b0;
      #1;
      chk("abort_cs", {63'h0, b_ram_cs}, 64'h0);
      chk("abort_oe", {63'h0, b_ram_oe}, 64'h0);
      chk("abort_addr", b_bus_addr, 64'h0);
      p0_req = 0;
      dones = 0;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk);
         #1;
         if (b_p0_done || b_p1_done) dones++;
         if (i == 2) reset = 1'b1;
      end
      chk("abort_no_done", 64'(dones), 64'h0);

      // Fresh load/store read completes normally after reset
      p1_req = 1; p1_we = 0; p1_addr = 64'h600;
      sb.push_back('{1'b1, 1'b0, 64'h600, 64'h0, 64'hFEEDFACE12345678});
      monitor(1, 3);
      p1_req = 0;
      idle(2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
